// File: rtl/input_port_vc_buffer_pkg.sv
// Shared definitions for the input-port VC buffer slice.
// Holds default geometry, flit field offsets, the look-ahead route encoding
// and small helpers used by the buffer, its FIFO and its interface.
package input_port_vc_buffer_pkg;

   localparam int unsigned VC_NUM_DEF   = 2;
   localparam int unsigned VC_DEPTH_DEF = 4;
   localparam int unsigned FLIT_W_DEF   = 33;

   // Flit field offsets (LSB position and width)
   localparam int unsigned DST_X_LSB    = 31;
   localparam int unsigned DST_X_W      = 2;
   localparam int unsigned DST_Y_LSB    = 29;
   localparam int unsigned DST_Y_W      = 2;
   localparam int unsigned DST_PORT_LSB = 27;
   localparam int unsigned DST_PORT_W   = 2;
   localparam int unsigned LA_ROUTE_LSB = 4;
   localparam int unsigned LA_ROUTE_W   = 3;

   // Look-ahead route encoding for this hop
   typedef enum logic [2:0] {
      ROUTE_POS_Y = 3'd0,
      ROUTE_NEG_Y = 3'd1,
      ROUTE_POS_X = 3'd2,
      ROUTE_NEG_X = 3'd3,
      ROUTE_LOCAL = 3'd4
   } route_e;

   // VC index width: max(1, clog2(n))
   function automatic int unsigned vc_id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic route_e flit_la_route(input logic [FLIT_W_DEF-1:0] flit);
      return route_e'(flit[LA_ROUTE_LSB +: LA_ROUTE_W]);
   endfunction

endpackage

// File: rtl/input_port_vc_buffer_if.sv
// Bus between the upstream link / switch allocator and the input-port VC buffer.
// slave  : the buffer (receives flits and pop grants, drives heads, credits, errors)
// master : the environment driving flits and pop grants
// Signals:
//   flit_vld_i, flit_vc_id_i, flit_i   incoming flit
//   pop_vld_i, pop_vc_id_i             switch-traversal grant
//   vc_ctrl_head_vld_o, vc_ctrl_head_o per-VC head valid and head flit
//   credit_vld_o, credit_vc_id_o       credit return upstream
//   overflow_err_o, underflow_err_o    sticky error flags
interface input_port_vc_buffer_if
   import input_port_vc_buffer_pkg::*;
#(
   parameter int unsigned VC_NUM  = VC_NUM_DEF,
   parameter int unsigned FLIT_W  = FLIT_W_DEF,
   parameter int unsigned VC_ID_W = vc_id_width(VC_NUM)
);

   logic                     flit_vld_i;
   logic [VC_ID_W-1:0]       flit_vc_id_i;
   logic [FLIT_W-1:0]        flit_i;
   logic                     pop_vld_i;
   logic [VC_ID_W-1:0]       pop_vc_id_i;
   logic [VC_NUM-1:0]        vc_ctrl_head_vld_o;
   logic [VC_NUM*FLIT_W-1:0] vc_ctrl_head_o;
   logic                     credit_vld_o;
   logic [VC_ID_W-1:0]       credit_vc_id_o;
   logic                     overflow_err_o;
   logic                     underflow_err_o;

   modport slave (
      input  flit_vld_i, flit_vc_id_i, flit_i, pop_vld_i, pop_vc_id_i,
      output vc_ctrl_head_vld_o, vc_ctrl_head_o, credit_vld_o, credit_vc_id_o,
             overflow_err_o, underflow_err_o
   );

   modport master (
      output flit_vld_i, flit_vc_id_i, flit_i, pop_vld_i, pop_vc_id_i,
      input  vc_ctrl_head_vld_o, vc_ctrl_head_o, credit_vld_o, credit_vc_id_o,
             overflow_err_o, underflow_err_o
   );

endinterface

// File: rtl/noc_vc_fifo.sv
// Single-VC circular flit FIFO.
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   push_i        write data_i (dropped when full unless popped this cycle)
//   data_i        flit to write
//   pop_i         dequeue head (ignored when empty)
//   head_o        mem[rd_ptr], combinational read of registered storage
//   head_vld_o    FIFO non-empty
//   full_o        occupancy == DEPTH
//   pop_ok_o      pop accepted this cycle
//   underflow_o   pop requested while empty (single-cycle indication)
module noc_vc_fifo
   import input_port_vc_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = VC_DEPTH_DEF,
   parameter int unsigned W     = FLIT_W_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         head_vld_o,
   output logic         full_o,
   output logic         pop_ok_o,
   output logic         underflow_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;

   always_comb begin
      full_o      = (count == CNT_W'(DEPTH));
      head_vld_o  = (count != '0);
      pop_ok_o    = pop_i && head_vld_o;
      // a full FIFO still accepts a push when its head leaves in the same cycle
      push_ok     = push_i && (!full_o || pop_ok_o);
      underflow_o = pop_i && !head_vld_o;
      head_o      = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok_o) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok_o})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/input_port_vc_buffer.sv
// Per-input-port virtual-channel flit buffer.
// One noc_vc_fifo per VC; decodes push/pop VC ids, presents each VC head,
// returns one registered credit per accepted pop and keeps sticky
// overflow/underflow flags (out-of-range VC ids count as errors).
// Ports:
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   input_port_vc_buffer_if.slave (flit in, pop grant, heads, credits, errors)
module input_port_vc_buffer
   import input_port_vc_buffer_pkg::*;
#(
   parameter int unsigned VC_NUM   = VC_NUM_DEF,
   parameter int unsigned VC_DEPTH = VC_DEPTH_DEF,
   parameter int unsigned FLIT_W   = FLIT_W_DEF,
   parameter int unsigned VC_ID_W  = vc_id_width(VC_NUM)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input_port_vc_buffer_if.slave   bus
);

   logic [VC_NUM-1:0] push_v;
   logic [VC_NUM-1:0] pop_v;
   logic [VC_NUM-1:0] full_v;
   logic [VC_NUM-1:0] pop_ok_v;
   logic [VC_NUM-1:0] udf_v;
   logic [VC_NUM-1:0] head_vld_v;
   logic [FLIT_W-1:0] head_v [VC_NUM];
   logic              push_oor;
   logic              pop_oor;
   logic              ovf_event;
   logic              udf_event;
   logic              pop_any_ok;

   always_comb begin
      push_v = '0;
      pop_v  = '0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         push_v[v] = bus.flit_vld_i && (32'(bus.flit_vc_id_i) == v);
         pop_v[v]  = bus.pop_vld_i  && (32'(bus.pop_vc_id_i)  == v);
      end
      push_oor   = bus.flit_vld_i && (32'(bus.flit_vc_id_i) >= VC_NUM);
      pop_oor    = bus.pop_vld_i  && (32'(bus.pop_vc_id_i)  >= VC_NUM);
      pop_any_ok = |pop_ok_v;
      // dropped push: target full and its head is not leaving this cycle
      ovf_event  = push_oor || (|(push_v & full_v & ~pop_ok_v));
      udf_event  = pop_oor  || (|udf_v);
   end

   for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
      noc_vc_fifo #(
         .DEPTH (VC_DEPTH),
         .W     (FLIT_W)
      ) u_fifo (
         .clk         (clk),
         .rstn        (rstn),
         .push_i      (push_v[g]),
         .data_i      (bus.flit_i),
         .pop_i       (pop_v[g]),
         .head_o      (head_v[g]),
         .head_vld_o  (head_vld_v[g]),
         .full_o      (full_v[g]),
         .pop_ok_o    (pop_ok_v[g]),
         .underflow_o (udf_v[g])
      );
   end

   always_comb begin
      bus.vc_ctrl_head_vld_o = head_vld_v;
      bus.vc_ctrl_head_o     = '0;
      for (int unsigned v = 0; v < VC_NUM; v++) begin
         bus.vc_ctrl_head_o[v*FLIT_W +: FLIT_W] = head_v[v];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         bus.credit_vld_o    <= 1'b0;
         bus.credit_vc_id_o  <= '0;
         bus.overflow_err_o  <= 1'b0;
         bus.underflow_err_o <= 1'b0;
      end else begin
         bus.credit_vld_o <= pop_any_ok;
         if (pop_any_ok) begin
            bus.credit_vc_id_o <= bus.pop_vc_id_i;
         end
         if (ovf_event) begin
            bus.overflow_err_o <= 1'b1;
         end
         if (udf_event) begin
            bus.underflow_err_o <= 1'b1;
         end
      end
   end

endmodule

// File: doc/input_port_vc_buffer.md
Name: input_port_vc_buffer

Overview:
Per-input-port virtual-channel flit buffer of the mesh router. It accepts flits from the upstream link into one FIFO per VC and presents each VC's head flit (vc_ctrl_head) with a valid flag to the look-ahead routing and VC/switch allocation stages. It dequeues a flit on switch-traversal grant and returns one credit per dequeued flit to the upstream router.

Parameters:
VC_NUM, 2, number of virtual channels per input port
VC_DEPTH, 4, flit slots per VC; must be a power of 2, at least 2
FLIT_W, 33, flit/control-head width
VC_ID_W, 1, width of VC index; equals max(1, clog2(VC_NUM))

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flit_vld_i  in  1  incoming flit valid
flit_vc_id_i  in  VC_ID_W  target VC of incoming flit
flit_i  in  FLIT_W  incoming flit; [32:31] dst x, [30:29] dst y, [28:27] dst device port, [6:4] look-ahead route for this hop
pop_vld_i  in  1  switch-traversal grant; dequeue one flit
pop_vc_id_i  in  VC_ID_W  VC to dequeue
vc_ctrl_head_vld_o  out  VC_NUM  per-VC head valid (VC is non-empty)
vc_ctrl_head_o  out  VC_NUM*FLIT_W  per-VC head flit; VC v occupies [v*FLIT_W +: FLIT_W]
credit_vld_o  out  1  credit return to upstream
credit_vc_id_o  out  VC_ID_W  VC of returned credit
overflow_err_o  out  1  sticky: push to a full VC was dropped
underflow_err_o  out  1  sticky: pop of an empty VC was ignored

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rstn sampled on the rising edge of clk).
- Reset values:
  - All counts and pointers are 0.
  - vc_ctrl_head_vld_o = 0, credit_vld_o = 0, credit_vc_id_o = 0.
  - Both error flags = 0.
  - vc_ctrl_head_o data is don't-care while its valid bit is 0, but is driven to 0 out of reset.
- Reset mid-operation discards all stored flits. No credits are returned for discarded flits; upstream resets together with this block.
- Per-VC storage:
  - Circular array of VC_DEPTH entries, with write pointer, read pointer and occupancy count.
  - Count width is clog2(VC_DEPTH+1). Pointers wrap modulo VC_DEPTH.
- Push:
  - Occurs when flit_vld_i=1. flit_i is written at wr_ptr[flit_vc_id_i] on the clock edge, then wr_ptr increments and count increments.
  - A push is accepted if count < VC_DEPTH, or if a pop of the same VC happens in the same cycle.
  - Otherwise the flit is dropped and overflow_err_o sets.
- Head latency:
  - There is no combinational bypass. A flit pushed into an empty VC at edge N shows vc_ctrl_head_vld_o[v]=1 and its data from edge N onward (registered storage, combinational head read).
  - vc_ctrl_head_o[v] is always mem[v][rd_ptr[v]]. vc_ctrl_head_vld_o[v] = (count[v] != 0).
- Pop:
  - Occurs when pop_vld_i=1 and count[pop_vc_id_i] > 0. rd_ptr increments and count decrements.
  - Pop of an empty VC is ignored and sets underflow_err_o.
  - At most one pop per cycle, because a port gets one crossbar slot.
- Simultaneous push and pop on the same VC: count is unchanged, and both pointers advance.
  - If the VC was empty, the pop is an underflow and the push still lands.
  - If the VC was full, both are legal.
- Simultaneous push and pop on different VCs are independent.
- Credits:
  - credit_vld_o is registered and asserts exactly one cycle after each accepted pop.
  - credit_vc_id_o equals the popped VC in that cycle. Otherwise credit_vld_o = 0.
  - Ignored pops return no credit.
- Error flags are sticky until reset.
- An out-of-range VC id (>= VC_NUM) on push or pop is treated as an overflow or underflow error respectively, and is ignored.

Decomposition:
- Shared package:
  - Flit field offsets (dst x [32:31], dst y [30:29], dst port [28:27], look-ahead route [6:4]).
  - Route encoding constants: 0 = +y, 1 = -y, 2 = +x, 3 = -x, 4 = local.
  - Default VC_NUM and VC_DEPTH values.
- One sub-module, noc_vc_fifo:
  - Single-VC FIFO with push_i, pop_i, head_o, head_vld_o, full_o, and overflow/underflow indications.
  - input_port_vc_buffer instantiates VC_NUM copies, decodes VC ids and registers the credit.

Test Plan:
- Reset then idle -> all vc_ctrl_head_vld_o=0, credit_vld_o=0, both error flags=0.
- Push flit 0x1_8000_0020 into VC1 at edge N -> vc_ctrl_head_vld_o=2'b10 and vc_ctrl_head_o[65:33]=0x1_8000_0020 from edge N. VC0 unaffected.
- Push 4 flits A,B,C,D into VC0, then pop 4 -> heads seen in order A,B,C,D. Credit pulses with credit_vc_id_o=0 one cycle after each pop. VC0 empty afterwards; pointers wrapped to 0.
- VC0 full (4 flits), push E to VC0 with no pop -> E dropped, overflow_err_o=1 and stays 1, head still A.
- VC0 full, push E and pop VC0 in the same cycle -> head becomes B, count stays 4, E is delivered 4th after later pops, no error.
- Pop VC1 while VC1 empty -> underflow_err_o=1, no credit, no state change. Then assert rstn=0 for one cycle with VC0 holding 2 flits -> VC0 empty and error flags cleared.
